// File: rtl/adc_spi_receiver_pkg.sv
// Shared definitions for the ADC SPI receiver: FSM states, frame geometry
// and the offset-binary to two's complement conversion.
package adc_spi_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } adc_state_t;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_DATA_BITS  = 12;
  localparam int unsigned ADC_MIDSCALE   = 2048;

  // Offset-binary code to signed value: code - midscale in 13-bit signed.
  function automatic logic signed [ADC_DATA_BITS:0] offset_code(
    input logic [ADC_DATA_BITS-1:0] code
  );
    logic signed [ADC_DATA_BITS:0] ext;
    ext = $signed({1'b0, code});
    return ext - $signed((ADC_DATA_BITS+1)'(ADC_MIDSCALE));
  endfunction

endpackage

// File: rtl/adc_spi_receiver_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_spi_receiver.sv
// SPI master for a 12-bit serial ADC with a 16-clock frame. One conversion
// per sample period; the offset-binary code is published as a signed
// Q(N-1-FRAC).FRAC word on 'sample' with a one-cycle 'sample_valid' strobe.
module adc_spi_receiver
  import adc_spi_receiver_pkg::*;
#(
  parameter int N       = 25,
  parameter int FRAC    = 16,
  parameter int CLK_DIV = 4,
  parameter int FS_DIV  = 2268
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         adc_sdata,
  output logic         adc_cs_n,
  output logic         adc_sclk,
  output logic [N-1:0] sample,
  output logic         sample_valid,
  output logic         overrun
);

  localparam int TW = $clog2(FS_DIV);
  localparam int DW = $clog2(CLK_DIV);

  adc_state_t state_q, state_d;

  logic [TW-1:0] tmr;
  logic          tick;
  logic          sdata_sync;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [ADC_DATA_BITS-1:0] shift_q;
  logic [ADC_DATA_BITS-1:0] code_next;
  logic          half_end;
  logic          start;
  logic          capture;
  logic          finish;

  // Sign-extend the offset-corrected code to N bits and align it to FRAC.
  function automatic logic [N-1:0] format_code(input logic [ADC_DATA_BITS-1:0] code);
    logic signed [ADC_DATA_BITS:0] d;
    logic signed [N-1:0]           e;
    d = offset_code(code);
    e = N'(d);
    return e <<< (FRAC - 11);
  endfunction

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (adc_sdata),
    .q     (sdata_sync)
  );

  assign tick      = (tmr == TW'(FS_DIV - 1));
  assign half_end  = (div_cnt == DW'(CLK_DIV - 1));
  assign code_next = {shift_q[ADC_DATA_BITS-2:0], sdata_sync};

  // Free-running sample period timer, independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (tick) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control strobes. The SCLK level tells which
  // half-period is running, so a capture is the end of a low half.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick && enable) begin
          start   = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (half_end && !adc_sclk) begin
          capture = 1'b1;
          if (bit_cnt == 4'd0) begin
            finish  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // SPI waveform generation, bit counting and serial capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else if (start) begin
      adc_cs_n <= 1'b0;
      adc_sclk <= 1'b1;
      div_cnt  <= '0;
      bit_cnt  <= 4'(ADC_FRAME_BITS - 1);
      shift_q  <= '0;
    end else if (state_q == ST_CONVERT) begin
      if (half_end) begin
        div_cnt  <= '0;
        adc_sclk <= ~adc_sclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (capture) begin
        shift_q <= code_next;
        if (bit_cnt != 4'd0) begin
          bit_cnt <= bit_cnt - 4'd1;
        end
      end
      if (finish) begin
        adc_cs_n <= 1'b1;
        adc_sclk <= 1'b1;
      end
    end
  end

  // Publish the formatted sample on the final rising edge so that sample and
  // sample_valid are both presented during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= finish;
      if (finish) begin
        sample <= format_code(code_next);
      end
    end
  end

  // Sticky flag for sample ticks that arrive while a frame is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (tick && (state_q != ST_IDLE)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_spi_receiver.sv
// Scoreboard bench for adc_spi_receiver: a default instance and a fast
// instance whose sample period is shorter than a frame.
module tb_adc_spi_receiver;

  localparam int N        = 25;
  localparam int CLK_DIV  = 4;
  localparam int FS_DIV   = 2268;
  localparam int CLK_DIV2 = 3;
  localparam int FS_DIV2  = 90;

  logic clk;
  logic rst_n, enable, adc_sdata, adc_cs_n, adc_sclk, sample_valid, overrun;
  logic [N-1:0] sample;
  logic rst2_n, enable2, adc_sdata2, adc_cs_n2, adc_sclk2, sample_valid2, overrun2;
  logic [N-1:0] sample2;

  int nchk = 0;
  int nerr = 0;
  int unsigned cyc = 0;

  logic [11:0] codeq1[$], codeq2[$];
  int          expq1[$], expq2[$];
  int unsigned vt[$];
  int          falls1 = 0, falls2 = 0;

  adc_spi_receiver #(.N(N), .FRAC(16), .CLK_DIV(CLK_DIV), .FS_DIV(FS_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_sdata(adc_sdata),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample(sample),
    .sample_valid(sample_valid), .overrun(overrun)
  );

  adc_spi_receiver #(.N(N), .FRAC(16), .CLK_DIV(CLK_DIV2), .FS_DIV(FS_DIV2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .enable(enable2), .adc_sdata(adc_sdata2),
    .adc_cs_n(adc_cs_n2), .adc_sclk(adc_sclk2), .sample(sample2),
    .sample_valid(sample_valid2), .overrun(overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] s25(input int v);
    return {7'b0, v[24:0]};
  endfunction

  task automatic push(input int which, input logic [11:0] code, input int exp, input bit publish);
    if (which == 1) begin
      codeq1.push_back(code);
      if (publish) expq1.push_back(exp);
    end else begin
      codeq2.push_back(code);
      if (publish) expq2.push_back(exp);
    end
  endtask

  task automatic wait_cs_fall(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 1) ? adc_cs_n : adc_cs_n2) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(which == 1 ? "cs_fall_timeout1" : "cs_fall_timeout2",
          {31'b0, ((which == 1) ? adc_cs_n : adc_cs_n2)}, 32'd0);
  endtask

  // ADC models: frame loaded at CS fall, next bit driven after each SCLK fall.
  logic [15:0] fr1, fr2;
  int idx1, idx2;

  always @(negedge adc_cs_n) begin
    if (codeq1.size() > 0) fr1 = {4'b0, codeq1.pop_front()};
    else begin
      fr1 = '0;
      nchk++; nerr++;
      $display("FAIL adc1_no_code: got frame start expected none");
    end
    idx1 = 15;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n == 1'b0) begin
      #1;
      if (idx1 >= 0) begin
        adc_sdata = fr1[idx1];
        idx1--;
      end
    end
  end

  always @(negedge adc_cs_n2) begin
    if (codeq2.size() > 0) fr2 = {4'b0, codeq2.pop_front()};
    else begin
      fr2 = '0;
      nchk++; nerr++;
      $display("FAIL adc2_no_code: got frame start expected none");
    end
    idx2 = 15;
  end

  always @(negedge adc_sclk2) begin
    if (adc_cs_n2 == 1'b0) begin
      #1;
      if (idx2 >= 0) begin
        adc_sdata2 = fr2[idx2];
        idx2--;
      end
    end
  end

  // Monitors: pop the scoreboard on each valid, and measure CS-low length.
  logic prev_v1 = 1'b0, prev_v2 = 1'b0;
  int cslen1 = 0, cslen2 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v1 = 1'b0;
      cslen1  = 0;
    end else begin
      if (sample_valid) begin
        check("valid_single1", {31'b0, prev_v1}, 32'd0);
        vt.push_back(cyc);
        if (expq1.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_valid1: got sample 0x%0h expected no pulse", sample);
        end else check("sample1", {7'b0, sample}, s25(expq1.pop_front()));
      end
      prev_v1 = sample_valid;
      if (!adc_cs_n) begin
        if (cslen1 == 0) falls1++;
        cslen1++;
      end else if (cslen1 != 0) begin
        check("cs_low_len1", cslen1, 32 * CLK_DIV);
        cslen1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst2_n) begin
      prev_v2 = 1'b0;
      cslen2  = 0;
    end else begin
      if (sample_valid2) begin
        check("valid_single2", {31'b0, prev_v2}, 32'd0);
        if (expq2.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_valid2: got sample 0x%0h expected no pulse", sample2);
        end else check("sample2", {7'b0, sample2}, s25(expq2.pop_front()));
      end
      prev_v2 = sample_valid2;
      if (!adc_cs_n2) begin
        if (cslen2 == 0) falls2++;
        cslen2++;
      end else if (cslen2 != 0) begin
        check("cs_low_len2", cslen2, 32 * CLK_DIV2);
        cslen2 = 0;
      end
    end
  end

  initial begin
    int f0;
    int nv;
    rst_n = 1'b0; rst2_n = 1'b0;
    enable = 1'b0; enable2 = 1'b0;
    adc_sdata = 1'b0; adc_sdata2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'b0, adc_cs_n}, 32'd1);
    check("rst_sclk", {31'b0, adc_sclk}, 32'd1);
    check("rst_sample", {7'b0, sample}, 32'd0);
    check("rst_valid", {31'b0, sample_valid}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);
    rst_n = 1'b1;

    // Full scale, zero scale, midscale, then small offsets around midscale.
    push(1, 12'hFFF, 65504, 1);
    push(1, 12'h000, -65536, 1);
    push(1, 12'h800, 0, 1);
    push(1, 12'h801, 32, 1);
    push(1, 12'h7FF, -32, 1);
    push(1, 12'hA00, 16384, 1);
    enable = 1'b1;
    repeat (6 * FS_DIV + 200) @(negedge clk);
    enable = 1'b0;
    check("frames_run", vt.size(), 6);
    for (int i = 1; i < vt.size(); i++) check("valid_period", vt[i] - vt[i-1], FS_DIV);
    check("overrun_clear", {31'b0, overrun}, 32'd0);
    check("cs_falls", falls1, 6);

    // Disabled across two ticks: nothing moves, sample holds.
    f0 = falls1;
    nv = vt.size();
    repeat (2 * FS_DIV) @(negedge clk);
    check("disabled_no_cs", falls1, f0);
    check("disabled_no_valid", vt.size(), nv);
    check("disabled_cs_high", {31'b0, adc_cs_n}, 32'd1);
    check("sample_hold", {7'b0, sample}, s25(16384));

    // Enable dropped mid-frame: the frame still publishes.
    push(1, 12'h123, -56224, 1);
    enable = 1'b1;
    wait_cs_fall(1, 3 * FS_DIV);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (200) @(negedge clk);
    check("enable_drop_publish", vt.size(), nv + 1);

    // Asynchronous reset during bit 7 of a frame.
    push(1, 12'h555, 0, 0);
    enable = 1'b1;
    wait_cs_fall(1, 3 * FS_DIV);
    repeat (69) @(negedge clk);
    check("sclk_low_bit7", {31'b0, adc_sclk}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_cs_n", {31'b0, adc_cs_n}, 32'd1);
    check("abort_sclk", {31'b0, adc_sclk}, 32'd1);
    check("abort_sample", {7'b0, sample}, 32'd0);
    check("abort_valid", {31'b0, sample_valid}, 32'd0);
    repeat (3) @(negedge clk);
    nv = vt.size();
    rst_n = 1'b1;
    push(1, 12'h3C0, -34816, 1);
    repeat (FS_DIV + 200) @(negedge clk);
    enable = 1'b0;
    check("clean_after_reset", vt.size(), nv + 1);
    check("overrun_after_reset", {31'b0, overrun}, 32'd0);

    // Sample period shorter than a frame: second tick lands mid-frame.
    rst2_n = 1'b1;
    push(2, 12'hC00, 32768, 1);
    push(2, 12'h001, -65504, 1);
    enable2 = 1'b1;
    wait_cs_fall(2, 200);
    repeat (100) @(negedge clk);
    check("overrun_set", {31'b0, overrun2}, 32'd1);
    wait_cs_fall(2, 300);
    repeat (110) @(negedge clk);
    enable2 = 1'b0;
    repeat (200) @(negedge clk);
    check("overrun_sticky", {31'b0, overrun2}, 32'd1);
    check("fast_frames", falls2, 2);

    check("pending_expected1", expq1.size(), 0);
    check("pending_expected2", expq2.size(), 0);
    check("unused_codes1", codeq1.size(), 0);
    check("unused_codes2", codeq2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
